mem_stage_ctrl: RTL and testbench
=================================

Name: mem_stage_ctrl

Overview:
- Memory-stage consumer of the EX/MEM pipeline register outputs.
- Turns mem_read/mem_write into a req/ack data-memory transaction and stalls the upstream pipeline until the access completes.
- Drives the MEM/WB register outputs (load data, ALU result, writeback control) for the writeback stage.

Parameters:
- DATA_W, 32, data/address width of ALU result, store data, memory bus.
- RD_W, 5, destination-register index width.

Ports:
- clk  in  1  clock
- rst  in  1  reset
- alu_result_in  in  DATA_W  EX/MEM ALU result; memory address for loads/stores
- write_data_in  in  DATA_W  EX/MEM store data
- rd_in  in  RD_W  EX/MEM destination register
- mem_to_reg_in  in  2  EX/MEM writeback-select
- reg_dst_in  in  2  EX/MEM reg-dst select
- mem_read_in  in  1  EX/MEM load
- mem_write_in  in  1  EX/MEM store
- reg_write_in  in  1  EX/MEM register-write enable
- dmem_req  out  1  memory request, held until ack
- dmem_we  out  1  1=write, 0=read
- dmem_addr  out  DATA_W  access address
- dmem_wdata  out  DATA_W  store data
- dmem_rdata  in  DATA_W  load data, valid with dmem_ack
- dmem_ack  in  1  one-cycle completion pulse
- stall  out  1  freeze PC/IF-ID/ID-EX/EX-MEM (combinational)
- read_data_out  out  DATA_W  MEM/WB load data
- alu_result_out  out  DATA_W  MEM/WB ALU result
- rd_out  out  RD_W  MEM/WB destination
- mem_to_reg_out  out  2  MEM/WB writeback-select
- reg_dst_out  out  2  MEM/WB reg-dst
- reg_write_out  out  1  MEM/WB register-write enable
- misalign_err  out  1  sticky misaligned-access flag (see Optional Feature)

Behaviour:
- Reset rst, synchronous, active-high; clock clk. On reset all outputs 0, FSM to IDLE.
- FSM states: IDLE, ACCESS, DONE.
- IDLE, no access (mem_read_in=mem_write_in=0):
  - stall=0; MEM/WB loads inputs at the edge.
  - read_data_out<=0. Latency 1 cycle, identical to a plain pipeline register.
- IDLE, access (either of mem_read_in or mem_write_in = 1):
  - stall=1.
  - At the edge: dmem_req<=1, dmem_we<=mem_write_in, dmem_addr<=alu_result_in, dmem_wdata<=write_data_in; go to ACCESS.
- ACCESS:
  - stall=1; req/we/addr/wdata held stable.
  - On dmem_ack: capture dmem_rdata internally (0 if write), dmem_req<=0, go to DONE.
  - Otherwise remain in ACCESS indefinitely.
- DONE:
  - stall=0. Inputs still hold the same instruction (upstream was frozen).
  - MEM/WB loads inputs with read_data_out<=captured data; next state IDLE.
- Any cycle with stall=1: MEM/WB loads a bubble (reg_write_out=0, rd_out=0, mem_to_reg_out=0, reg_dst_out=0, alu_result_out=0, read_data_out=0). No duplicate writeback.
- Minimum memory-op latency: req visible cycle 1, ack earliest cycle 1, MEM/WB valid after cycle 2 edge. stall high for at least 2 cycles.
- mem_read_in and mem_write_in both 1: treated as write; read_data_out=0.
- dmem_ack in IDLE or DONE is ignored.
- Back-to-back memory ops: a new access is detected in IDLE the cycle after DONE. No lost or merged accesses.
- rst mid-ACCESS: dmem_req drops at that edge, outstanding access abandoned, a late ack is ignored.

Optional Feature:
- Macro MEM_ALIGN_CHECK_EN.
- Defined:
  - An access in IDLE with alu_result_in[1:0]!=0 issues no dmem_req and no stall.
  - MEM/WB loads a bubble (reg_write_out=0).
  - misalign_err<=1, sticky until rst.
- Undefined: misalign_err tied 0; addresses are passed unchecked.

Test Plan:
- Reset then ALU op (alu_result_in=0x1234, rd_in=5, reg_write_in=1) -> next cycle alu_result_out=0x1234, rd_out=5, reg_write_out=1, stall never high.
- Load addr 0x40, ack one cycle after req, dmem_rdata=0xDEADBEEF -> stall high 2 cycles, dmem_we=0, dmem_addr=0x40; read_data_out=0xDEADBEEF with reg_write_out=1 after DONE; bubbles (reg_write_out=0) during stall.
- Store addr 0x80 data 0xCAFEF00D, ack delayed 5 cycles -> dmem_req/addr/wdata stable 5 cycles, stall high 6 cycles, one request only, read_data_out=0.
- Load then store back-to-back -> two distinct req transactions in order, one MEM/WB valid output per instruction, no dropped op.
- rst asserted in ACCESS, ack arrives 2 cycles later -> dmem_req=0 after reset edge, all outputs 0, ack ignored, FSM IDLE.
- MEM_ALIGN_CHECK_EN defined, load addr 0x42 -> no dmem_req, stall=0, reg_write_out=0, misalign_err=1 held until rst.

Source files
------------

// File: rtl/mem_stage_ctrl.sv
// Memory-stage controller: turns EX/MEM load/store control into a req/ack
// data-memory transaction, stalls upstream while it is outstanding, and
// drives the MEM/WB register for writeback.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   *_in                EX/MEM register outputs (alu result/address, store
//                       data, rd, writeback select, reg-dst, rd/wr/regwrite)
//   dmem_req/we/addr/wdata  memory request, held stable until dmem_ack
//   dmem_rdata, dmem_ack    load data and one-cycle completion pulse
//   stall               combinational freeze of PC/IF-ID/ID-EX/EX-MEM
//   *_out               MEM/WB register outputs
//   misalign_err        sticky misaligned-access flag
//
// Optional feature macro: MEM_ALIGN_CHECK_EN. When defined, a word access
// with a nonzero low address pair is dropped (bubble, no request) and
// misalign_err is set until reset. When undefined, misalign_err is 0.
module mem_stage_ctrl #(
    parameter int DATA_W = 32,
    parameter int RD_W   = 5
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] alu_result_in,
    input  logic [DATA_W-1:0] write_data_in,
    input  logic [RD_W-1:0]   rd_in,
    input  logic [1:0]        mem_to_reg_in,
    input  logic [1:0]        reg_dst_in,
    input  logic              mem_read_in,
    input  logic              mem_write_in,
    input  logic              reg_write_in,
    output logic              dmem_req,
    output logic              dmem_we,
    output logic [DATA_W-1:0] dmem_addr,
    output logic [DATA_W-1:0] dmem_wdata,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_ack,
    output logic              stall,
    output logic [DATA_W-1:0] read_data_out,
    output logic [DATA_W-1:0] alu_result_out,
    output logic [RD_W-1:0]   rd_out,
    output logic [1:0]        mem_to_reg_out,
    output logic [1:0]        reg_dst_out,
    output logic              reg_write_out,
    output logic              misalign_err
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              access;
    logic              misalign;
    logic              start;
    logic              wb_bubble;
    logic              ack_take;
    logic [DATA_W-1:0] cap_data;

    assign access = mem_read_in | mem_write_in;

`ifdef MEM_ALIGN_CHECK_EN
    assign misalign = access & (alu_result_in[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall     = 1'b0;
        start     = 1'b0;
        ack_take  = 1'b0;
        wb_bubble = 1'b0;
        unique case (state)
            IDLE: begin
                if (access && !misalign) begin
                    stall     = 1'b1;
                    start     = 1'b1;
                    state_nxt = ACCESS;
                end
                // A dropped misaligned access must not write back.
                wb_bubble = misalign;
            end
            ACCESS: begin
                stall = 1'b1;
                if (dmem_ack) begin
                    ack_take  = 1'b1;
                    state_nxt = DONE;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        if (stall) begin
            wb_bubble = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            dmem_req       <= 1'b0;
            dmem_we        <= 1'b0;
            dmem_addr      <= '0;
            dmem_wdata     <= '0;
            cap_data       <= '0;
            read_data_out  <= '0;
            alu_result_out <= '0;
            rd_out         <= '0;
            mem_to_reg_out <= '0;
            reg_dst_out    <= '0;
            reg_write_out  <= 1'b0;
        end else begin
            if (start) begin
                dmem_req   <= 1'b1;
                dmem_we    <= mem_write_in;
                dmem_addr  <= alu_result_in;
                dmem_wdata <= write_data_in;
            end
            if (ack_take) begin
                dmem_req <= 1'b0;
                cap_data <= dmem_we ? '0 : dmem_rdata;
            end
            if (wb_bubble) begin
                read_data_out  <= '0;
                alu_result_out <= '0;
                rd_out         <= '0;
                mem_to_reg_out <= '0;
                reg_dst_out    <= '0;
                reg_write_out  <= 1'b0;
            end else begin
                // Only the DONE cycle carries load data; plain ops pass 0.
                read_data_out  <= (state == DONE) ? cap_data : '0;
                alu_result_out <= alu_result_in;
                rd_out         <= rd_in;
                mem_to_reg_out <= mem_to_reg_in;
                reg_dst_out    <= reg_dst_in;
                reg_write_out  <= reg_write_in;
            end
        end
    end

`ifdef MEM_ALIGN_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_err <= 1'b0;
        end else if (state == IDLE && misalign) begin
            misalign_err <= 1'b1;
        end
    end
`else
    assign misalign_err = 1'b0;
`endif

endmodule

// File: tb/tb_mem_stage_ctrl.sv
// Scoreboard bench for mem_stage_ctrl: stimulus pushes expected MEM/WB and
// memory-request records; separate monitors pop and compare.
module tb_mem_stage_ctrl;

    localparam int DW = 32;
    localparam int RW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] alu_result_in;
    logic [DW-1:0] write_data_in;
    logic [RW-1:0] rd_in;
    logic [1:0]    mem_to_reg_in;
    logic [1:0]    reg_dst_in;
    logic          mem_read_in;
    logic          mem_write_in;
    logic          reg_write_in;
    logic          dmem_req;
    logic          dmem_we;
    logic [DW-1:0] dmem_addr;
    logic [DW-1:0] dmem_wdata;
    logic [DW-1:0] dmem_rdata = '0;
    logic          dmem_ack = 1'b0;
    logic          stall;
    logic [DW-1:0] read_data_out;
    logic [DW-1:0] alu_result_out;
    logic [RW-1:0] rd_out;
    logic [1:0]    mem_to_reg_out;
    logic [1:0]    reg_dst_out;
    logic          reg_write_out;
    logic          misalign_err;

    mem_stage_ctrl #(.DATA_W(DW), .RD_W(RW)) dut (
        .clk(clk),
        .rst(rst),
        .alu_result_in(alu_result_in),
        .write_data_in(write_data_in),
        .rd_in(rd_in),
        .mem_to_reg_in(mem_to_reg_in),
        .reg_dst_in(reg_dst_in),
        .mem_read_in(mem_read_in),
        .mem_write_in(mem_write_in),
        .reg_write_in(reg_write_in),
        .dmem_req(dmem_req),
        .dmem_we(dmem_we),
        .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata),
        .dmem_rdata(dmem_rdata),
        .dmem_ack(dmem_ack),
        .stall(stall),
        .read_data_out(read_data_out),
        .alu_result_out(alu_result_out),
        .rd_out(rd_out),
        .mem_to_reg_out(mem_to_reg_out),
        .reg_dst_out(reg_dst_out),
        .reg_write_out(reg_write_out),
        .misalign_err(misalign_err)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [4:0]  rd;
        logic [1:0]  m2r;
        logic [1:0]  rdst;
        logic        rw;
        logic [31:0] rdata;
    } wb_t;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } req_t;

    wb_t  wb_q[$];
    req_t req_q[$];
    int   total = 0;
    int   bad = 0;
    int   n_req = 0;

    int          ack_delay = 1;
    int          cnt = 0;
    logic [31:0] rd_val = '0;
    logic        inj_ack = 1'b0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    function automatic wb_t got_wb();
        return {alu_result_out, rd_out, mem_to_reg_out, reg_dst_out,
                reg_write_out, read_data_out};
    endfunction

    // Memory model: ack on the ack_delay-th cycle req is seen high.
    always @(negedge clk) begin
        if (dmem_req) cnt++;
        else cnt = 0;
        dmem_ack   = inj_ack || (dmem_req && cnt == ack_delay);
        dmem_rdata = dmem_ack ? rd_val : 32'h5A5A_5A5A;
    end

    // MEM/WB monitor.
    always @(posedge clk) begin
        logic s;
        logic r;
        wb_t  e;
        s = stall;
        r = rst;
        #1;
        if (!r) begin
            if (s) begin
                check("bubble", got_wb(), '0);
            end else if (wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check("wb", got_wb(), e);
            end else begin
                check("idle", got_wb(), '0);
            end
        end
    end

    // Request monitor.
    logic req_prev = 1'b0;
    req_t cur = '0;
    always @(negedge clk) begin
        if (dmem_req && !req_prev) begin
            n_req++;
            if (req_q.size() == 0) begin
                check("req_unexp", dmem_req, 0);
                cur = {dmem_we, dmem_addr, dmem_wdata};
            end else begin
                cur = req_q.pop_front();
                check("req", {dmem_we, dmem_addr, dmem_wdata}, cur);
            end
        end else if (dmem_req) begin
            check("req_hold", {dmem_we, dmem_addr, dmem_wdata}, cur);
        end
        req_prev = dmem_req;
    end

    task automatic clear_in();
        alu_result_in = '0;
        write_data_in = '0;
        rd_in         = '0;
        mem_to_reg_in = '0;
        reg_dst_in    = '0;
        mem_read_in   = 1'b0;
        mem_write_in  = 1'b0;
        reg_write_in  = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge after the op retires.
    task automatic op(input string nm, input logic [31:0] alu,
                      input logic [31:0] wd, input logic [4:0] rd,
                      input logic [1:0] m2r, input logic [1:0] rdst,
                      input logic mr, input logic mw, input logic rw,
                      input logic [31:0] exp_rdata, input int exp_stall,
                      input bit mis);
        int  st;
        bit  done;
        logic s;
        st = 0;
        done = 0;
        alu_result_in = alu;
        write_data_in = wd;
        rd_in         = rd;
        mem_to_reg_in = m2r;
        reg_dst_in    = rdst;
        mem_read_in   = mr;
        mem_write_in  = mw;
        reg_write_in  = rw;
        if (mis) begin
            wb_q.push_back('0);
        end else begin
            wb_q.push_back({alu, rd, m2r, rdst, rw, exp_rdata});
            if (mr | mw) req_q.push_back({mw, alu, wd});
        end
        for (int k = 0; k < 200; k++) begin
            #1;
            s = stall;
            if (s) st++;
            @(negedge clk);
            if (!s) begin
                done = 1;
                break;
            end
        end
        if (!done) check({nm, "_timeout"}, 1, 0);
        clear_in();
        check({nm, "_stall"}, st, exp_stall);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    initial begin
        int r0;
        clear_in();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_wb", got_wb(), '0);
        check("rst_req", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, '0);
        check("rst_stall", stall, 0);
        check("rst_err", misalign_err, 0);
        rst = 1'b0;

        op("alu", 32'h1234, 0, 5, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
        op("alu2", 32'hFFFF_FFFF, 32'h99, 31, 2'd2, 2'd1, 0, 0, 1, 0, 0, 0);

        ack_delay = 1;
        rd_val = 32'hDEAD_BEEF;
        op("load", 32'h40, 0, 7, 2'd1, 2'd0, 1, 0, 1, 32'hDEAD_BEEF, 2, 0);

        r0 = n_req;
        ack_delay = 5;
        rd_val = 32'h1357_9BDF;
        op("store", 32'h80, 32'hCAFE_F00D, 0, 2'd0, 2'd0, 0, 1, 0, 0, 6, 0);
        check("store_nreq", n_req - r0, 1);

        r0 = n_req;
        ack_delay = 1;
        rd_val = 32'h1111_2222;
        op("b2b_ld", 32'h100, 0, 3, 2'd1, 2'd0, 1, 0, 1, 32'h1111_2222, 2, 0);
        op("b2b_st", 32'h104, 32'h3333_4444, 0, 2'd0, 2'd0, 0, 1, 0, 0, 2, 0);
        check("b2b_nreq", n_req - r0, 2);

        ack_delay = 2;
        rd_val = 32'h7777_8888;
        op("rdwr", 32'h200, 32'hABCD, 9, 2'd1, 2'd1, 1, 1, 1, 0, 3, 0);

        // Reset during ACCESS; the access is abandoned.
        ack_delay = 1000;
        rd_val = 32'hBAD0_BAD0;
        alu_result_in = 32'h300;
        rd_in = 4;
        mem_read_in = 1'b1;
        reg_write_in = 1'b1;
        req_q.push_back({1'b0, 32'h300, 32'h0});
        repeat (2) @(negedge clk);
        check("pre_rst_req", dmem_req, 1);
        rst = 1'b1;
        clear_in();
        @(negedge clk);
        check("mid_rst_wb", got_wb(), '0);
        check("mid_rst_req", {dmem_req, dmem_we, dmem_addr, dmem_wdata}, '0);
        check("mid_rst_stall", stall, 0);
        rst = 1'b0;
        @(negedge clk);
        inj_ack = 1'b1;
        @(negedge clk);
        inj_ack = 1'b0;
        #1;
        check("late_ack_stall", stall, 0);
        @(negedge clk);
        check("late_ack_req", dmem_req, 0);
        check("late_ack_wb", got_wb(), '0);
        ack_delay = 1;
        op("post_rst", 32'h55, 0, 6, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);

`ifdef MEM_ALIGN_CHECK_EN
        r0 = n_req;
        op("mis", 32'h42, 0, 8, 2'd1, 2'd0, 1, 0, 1, 0, 0, 1);
        check("mis_nreq", n_req - r0, 0);
        check("mis_err", misalign_err, 1);
        op("mis_after", 32'h66, 0, 2, 2'd0, 2'd0, 0, 0, 1, 0, 0, 0);
        check("mis_sticky", misalign_err, 1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mis_clr", misalign_err, 0);
`endif

        repeat (3) @(negedge clk);
        check("wb_q_empty", wb_q.size(), 0);
        check("req_q_empty", req_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
